// File: rtl/uart_recv.sv
// uart_recv: asynchronous serial receiver, 8 data bits, even parity, 1 stop bit.
//
// State table
//   IDLE   | line idle, waiting for a synchronized 1->0 edge
//   START  | verifying the start bit at its midpoint (cnt == HALF)
//   DATA   | sampling D0..D7 (LSB first), one bit every DIV+1 clocks
//   PARITY | sampling the parity bit
//   STOP   | sampling the stop bit, then back to IDLE and publish the frame
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   bps_set    : baud select 00=9600 01=19200 10=38400 11=921600
//   rs232_rx   : asynchronous serial input, idle high
//   data_in    : last received byte
//   rx_done    : one-cycle pulse when a frame completes
//   parity_err : even-parity mismatch in the last frame
//   frame_err  : stop bit sampled low in the last frame
//   rx_state   : 1 while a frame is being received (registered)
module uart_recv #(
  parameter logic [27:0] clk_in = 28'd50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] bps_set,
  input  logic       rs232_rx,
  output logic [7:0] data_in,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_state
);

  localparam logic [12:0] DIV_9600   = 13'(clk_in / 9600   - 1);
  localparam logic [12:0] DIV_19200  = 13'(clk_in / 19200  - 1);
  localparam logic [12:0] DIV_38400  = 13'(clk_in / 38400  - 1);
  localparam logic [12:0] DIV_921600 = 13'(clk_in / 921600 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nxt;
  logic [12:0] cnt, cnt_nxt;
  logic [12:0] div, div_nxt, div_sel, half;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        par_bit, par_nxt;
  logic        done_nxt;
  logic        rx_s1, rx_s2, rx_d;
  logic [1:0]  sync_warm;
  logic        fall;

  always_comb begin
    case (bps_set)
      2'b00:   div_sel = DIV_9600;
      2'b01:   div_sel = DIV_19200;
      2'b10:   div_sel = DIV_38400;
      default: div_sel = DIV_921600;
    endcase
  end

  assign half = {1'b0, div[12:1]};

  // The synchronizer flops come out of reset high. If the line is low at
  // release, that would look like a falling edge; sync_warm masks edge
  // detection until all three flops hold real line samples.
  assign fall = (sync_warm == 2'd3) && rx_d && !rx_s2;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = div;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fall) begin
          state_nxt = START;
          div_nxt   = div_sel;
        end
      end
      START: begin
        if (cnt == half) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          state_nxt = rx_s2 ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 13'd1;
        end
      end
      DATA: begin
        if (cnt == div) begin
          cnt_nxt = '0;
          shreg_nxt[idx] = rx_s2;
          idx_nxt = idx + 3'd1;
          if (idx == 3'd7) state_nxt = PARITY;
        end else begin
          cnt_nxt = cnt + 13'd1;
        end
      end
      PARITY: begin
        if (cnt == div) begin
          cnt_nxt   = '0;
          par_nxt   = rx_s2;
          state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + 13'd1;
        end
      end
      STOP: begin
        if (cnt == div) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 13'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      sync_warm  <= '0;
      data_in    <= 8'h00;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_state   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      div      <= div_nxt;
      idx      <= idx_nxt;
      shreg    <= shreg_nxt;
      par_bit  <= par_nxt;
      rx_s1    <= rs232_rx;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      if (sync_warm != 2'd3) sync_warm <= sync_warm + 2'd1;
      rx_done  <= done_nxt;
      rx_state <= (state != IDLE);
      // rx_s2 is the stop bit on the stop-sample cycle.
      if (done_nxt) begin
        data_in    <= shreg;
        parity_err <= (^shreg) ^ par_bit;
        frame_err  <= !rx_s2;
      end
    end
  end

endmodule
